// File: rtl/dmem_arbiter.sv
// Arbitrates the data RAM port between pipeline (P) and loader (L); grant is same-cycle, read data returns 1 cycle later.
// No buffering: an ungranted requester holds its request; P is stalled, L is protected by a starvation counter and bounded lock.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        p_req,
    input  logic        p_wr_en,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wr_data,
    output logic        p_gnt,
    output logic        p_stall,
    output logic        p_rd_valid,
    output logic [31:0] p_rd_data,
    input  logic        l_req,
    input  logic        l_wr_en,
    input  logic        l_lock,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wr_data,
    output logic        l_gnt,
    output logic        l_rd_valid,
    output logic [31:0] l_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_en,
    output logic        mem_en,
    input  logic [31:0] mem_rd_data
);

    localparam logic [1:0] ST_PRI_P   = 2'd0;
    localparam logic [1:0] ST_FORCE_L = 2'd1;
    localparam logic [1:0] ST_LOCK_L  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P    = 2'd1;
    localparam logic [1:0] OWN_L    = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] rd_owner_q, rd_owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       lock_blocked_q, lock_blocked_d;
    logic       lock_take;
    logic       lock_last;

    always_comb begin
        p_gnt = 1'b0;
        l_gnt = 1'b0;
        case (state_q)
            ST_PRI_P: begin
                p_gnt = p_req;
                l_gnt = ~p_req & l_req;
            end
            ST_FORCE_L: begin
                l_gnt = l_req;
                p_gnt = ~l_req & p_req;
            end
            default: begin
                l_gnt = l_req;
            end
        endcase
    end

    // A blocked lock request behaves like a plain loader access.
    assign lock_take = l_gnt & l_lock & ~lock_blocked_q;
    assign lock_last = (lock_cnt_q == LOCK_LAST);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = 4'd0;
        lock_cnt_d   = lock_cnt_q;
        case (state_q)
            ST_PRI_P: begin
                if (l_req & ~l_gnt) begin
                    starve_cnt_d = (starve_cnt_q >= STARVE_MAX) ? STARVE_MAX : 4'(starve_cnt_q + 4'd1);
                end
                if (lock_take) begin
                    state_d    = ST_LOCK_L;
                    lock_cnt_d = 8'd0;
                end else if (starve_cnt_d == STARVE_MAX) begin
                    state_d = ST_FORCE_L;
                end
            end
            ST_FORCE_L: begin
                if (lock_take) begin
                    state_d    = ST_LOCK_L;
                    lock_cnt_d = 8'd0;
                end else begin
                    state_d = ST_PRI_P;
                end
            end
            ST_LOCK_L: begin
                lock_cnt_d = 8'(lock_cnt_q + 8'd1);
                if (~l_lock | ~l_req | lock_last) begin
                    state_d = ST_PRI_P;
                end
            end
            default: begin
                state_d = ST_PRI_P;
            end
        endcase
    end

    always_comb begin
        lock_blocked_d = lock_blocked_q;
        if ((state_q == ST_LOCK_L) && lock_last && l_lock) begin
            lock_blocked_d = 1'b1;
        end else if (~l_lock) begin
            lock_blocked_d = 1'b0;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (p_gnt & ~p_wr_en) begin
            rd_owner_d = OWN_P;
        end else if (l_gnt & ~l_wr_en) begin
            rd_owner_d = OWN_L;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_PRI_P;
            rd_owner_q     <= OWN_NONE;
            starve_cnt_q   <= 4'd0;
            lock_cnt_q     <= 8'd0;
            lock_blocked_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_owner_q     <= rd_owner_d;
            starve_cnt_q   <= starve_cnt_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_blocked_q <= lock_blocked_d;
        end
    end

    assign p_stall     = p_req & ~p_gnt;
    assign mem_en      = p_gnt | l_gnt;
    assign mem_addr    = p_gnt ? p_addr    : (l_gnt ? l_addr    : 32'h0);
    assign mem_wr_data = p_gnt ? p_wr_data : (l_gnt ? l_wr_data : 32'h0);
    assign mem_wr_en   = p_gnt ? p_wr_en   : (l_gnt & l_wr_en);

    assign p_rd_valid = (rd_owner_q == OWN_P);
    assign l_rd_valid = (rd_owner_q == OWN_L);
    assign p_rd_data  = p_rd_valid ? mem_rd_data : 32'h0;
    assign l_rd_data  = l_rd_valid ? mem_rd_data : 32'h0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data-memory access path between the pipeline MEM stage (requester P) and the program/debug loader (requester L). Grants one request per cycle, forwards it to data memory, and routes the one-cycle-latency read data back to whichever requester issued the read. The block sits between the MEM stage and the data RAM port. Fairness and burst control come from a starvation counter and a bounded loader lock, and the pipeline is stalled whenever it is not granted.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied loader-request cycles before the loader is forced a grant (legal range 1..15).
- LOCK_MAX, 8: maximum consecutive cycles the loader may hold the memory under l_lock (legal range 1..255).

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- p_req  in  1  pipeline access request.
- p_wr_en  in  1  1 = store, 0 = load.
- p_addr  in  32  pipeline byte address.
- p_wr_data  in  32  pipeline store data (already masked).
- p_gnt  out  1  pipeline request accepted this cycle.
- p_stall  out  1  equals p_req & ~p_gnt.
- p_rd_valid  out  1  pipeline read data valid.
- p_rd_data  out  32  pipeline read data.
- l_req, l_wr_en, l_lock  in  1 each  loader request, store select, and lock-hold.
- l_addr, l_wr_data  in  32 each  loader address and store data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rd_valid  out  1  loader read data valid.
- l_rd_data  out  32  loader read data.
- mem_addr  out  32  data RAM address.
- mem_wr_data  out  32  data RAM write data.
- mem_wr_en  out  1  data RAM write enable.
- mem_en  out  1  data RAM port enable.
- mem_rd_data  in  32  synchronous RAM read data, valid the cycle after the address.

## Operation
- Grant decision is combinational from the current state and the requests. At most one of p_gnt and l_gnt is high in any cycle.
- Memory outputs mux the granted requester's addr, wr_data and wr_en. mem_en = p_gnt | l_gnt. With no grant: mem_en = 0, mem_wr_en = 0, mem_addr = 0, mem_wr_data = 0.
- Read tag: registered rd_owner in {NONE, P, L}.
  - Set to P or L on a granted read.
  - Set to NONE on a write or when there is no grant.
- Read return: x_rd_valid = (rd_owner == x). x_rd_data = mem_rd_data when valid, 0 otherwise.
- starve_cnt (4 bit):
  - Increments in PRI_P when l_req & ~l_gnt.
  - Clears on any l_gnt or when l_req = 0.
  - Saturates at STARVE_LIMIT.
- lock_cnt (8 bit): counts cycles spent in LOCK_L; cleared on entry to LOCK_L.

FSM states:
- PRI_P (reset state)
  - Grant: P if p_req; otherwise L if l_req.
  - To FORCE_L when starve_cnt reaches STARVE_LIMIT (the incrementing cycle's next state).
  - To LOCK_L when l_gnt & l_lock.
- FORCE_L
  - Grant: L if l_req; otherwise P if p_req.
  - If l_gnt & l_lock: go to LOCK_L.
  - Otherwise: go to PRI_P and clear starve_cnt.
- LOCK_L
  - Grant L only. p_gnt = 0.
  - Exit to PRI_P in the cycle after l_lock = 0, or after l_req = 0, or when lock_cnt == LOCK_MAX-1.
  - The exit cycle still grants L if l_req.
  - After a forced LOCK_MAX exit, l_lock is ignored until l_lock is seen low for one cycle (registered lock_blocked flag). This guarantees P a grant window.

## Timing
- Reset: state = PRI_P, rd_owner = NONE, starve_cnt = 0, lock_cnt = 0, lock_blocked = 0. All outputs are 0 during reset with no requests.
- Reset asserted mid-read: rd_valid drops immediately (asynchronous). The returned read is discarded.
- Grant latency: 0 cycles. Address, write enable and data reach memory in the request cycle.
- Write commit: at the rising edge ending the grant cycle.
- Read latency: 1 cycle. A read granted in cycle N returns in cycle N+1.
- Back-to-back reads from alternating requesters return in order, one per cycle.
- Requesters must hold their request and payload stable until granted.
- Both requesters in PRI_P: P wins. With continuous contention, L is granted on cycle STARVE_LIMIT+1 and P stalls exactly that cycle.
- Write and read to the same address in consecutive cycles: the read returns the new data (RAM is write-first).

## Test plan
- Reset, then P read of 0x100 (RAM holds 0xDEADBEEF) → p_gnt = 1 in cycle 0; p_rd_valid = 1, p_rd_data = 0xDEADBEEF in cycle 1; l_rd_valid = 0.
- p_req and l_req held high continuously, STARVE_LIMIT = 4 → p_gnt cycles 0-3; l_gnt and p_stall = 1 in cycle 4; p_gnt again in cycle 5; starve_cnt = 0 after cycle 4.
- Loader writes 0x11 to 0x200 then P reads 0x200 the next cycle → mem_wr_en = 1 in cycle 0, l_gnt = 1; p_rd_data = 0x11 in cycle 2.
- l_lock held, l_req held, p_req held, LOCK_MAX = 8, entered from an idle P → l_gnt for 8 LOCK_L cycles; p_gnt = 1 on the following cycle; a continued l_lock is ignored until it deasserts.
- Alternating P read of 0x0 and L read of 0x4 each cycle → p_rd_valid and l_rd_valid alternate, each carrying its own address's data, never both high together.
- Reset asserted during the cycle after a granted L read → l_rd_valid = 0 immediately; after release, state = PRI_P and a lone l_req is granted at once.
